// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw asynchronous level input. A stability FSM
// qualifies each candidate transition and counts aborted qualifications.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             clr_glitch,
    output logic             dout,
    output logic             busy,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int unsigned QW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [QW-1:0] QualMax = QW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StLo,
        StChkHi,
        StHi,
        StChkLo
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [QW-1:0]          cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       glitch_cnt_q, glitch_cnt_d;
    logic                   din_s;
    logic                   glitch;

    assign din_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        state_d = state_q;
        cnt_d   = cnt_q;
        glitch  = 1'b0;
        case (state_q)
            StLo: begin
                if (din_s) begin
                    state_d = StChkHi;
                    cnt_d   = QW'(1);
                end
            end
            StChkHi: begin
                if (!din_s) begin
                    state_d = StLo;
                    cnt_d   = '0;
                    glitch  = 1'b1;
                end else if (cnt_q == QualMax) begin
                    state_d = StHi;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHi: begin
                if (!din_s) begin
                    state_d = StChkLo;
                    cnt_d   = QW'(1);
                end
            end
            StChkLo: begin
                if (din_s) begin
                    state_d = StHi;
                    cnt_d   = '0;
                    glitch  = 1'b1;
                end else if (cnt_q == QualMax) begin
                    state_d = StLo;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StLo;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register with it.
        dout_d = (state_d == StHi) || (state_d == StChkLo);
        busy_d = (state_d == StChkHi) || (state_d == StChkLo);

        glitch_cnt_d = glitch_cnt_q;
        if (clr_glitch) begin
            glitch_cnt_d = '0;
        end else if (glitch && (glitch_cnt_q != '1)) begin
            glitch_cnt_d = glitch_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            state_q      <= StLo;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            busy_q       <= 1'b0;
            glitch_cnt_q <= '0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign busy       = busy_q;
    assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: vector table through a scoreboard queue, plus a
// saturation sequence on a narrow-counter instance.
module tb_debounce_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       clr_glitch = 1'b0;
    logic       dout, busy;
    logic [7:0] glitch_cnt;

    logic       din2 = 1'b0;
    logic       clr2 = 1'b0;
    logic       dout2, busy2;
    logic [1:0] glitch_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .clr_glitch (clr_glitch),
        .dout       (dout),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .din        (din2),
        .clr_glitch (clr2),
        .dout       (dout2),
        .busy       (busy2),
        .glitch_cnt (glitch_cnt2)
    );

    typedef struct {
        logic       din;
        logic       clr;
        logic       rst;
        logic       dout;
        logic       busy;
        logic [7:0] gc;
    } vec_t;

    typedef struct {
        int         idx;
        logic       dout;
        logic       busy;
        logic [7:0] gc;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    function automatic void add(input int n, input logic d, input logic c, input logic r,
                                input logic ed, input logic eb, input int eg);
        vec_t v;
        v.din  = d;
        v.clr  = c;
        v.rst  = r;
        v.dout = ed;
        v.busy = eb;
        v.gc   = 8'(eg);
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    int exp_rises = 0;
    int act_rises = 0;

    initial begin
        logic prev_exp;
        logic prev_act;
        exp_t e;
        int   sat_exp[5];

        // Reset held 2 edges with din high, then full requalification.
        add(2, 1, 0, 1, 0, 0, 0);
        add(2, 1, 0, 0, 0, 0, 0);
        add(3, 1, 0, 0, 0, 1, 0);
        add(3, 1, 0, 0, 1, 0, 0);
        // Clean fall.
        add(2, 0, 0, 0, 1, 0, 0);
        add(3, 0, 0, 0, 1, 1, 0);
        add(5, 0, 0, 0, 0, 0, 0);
        // Clean rise held 10, fall held 10.
        add(2, 1, 0, 0, 0, 0, 0);
        add(3, 1, 0, 0, 0, 1, 0);
        add(5, 1, 0, 0, 1, 0, 0);
        add(2, 0, 0, 0, 1, 0, 0);
        add(3, 0, 0, 0, 1, 1, 0);
        add(5, 0, 0, 0, 0, 0, 0);
        // Bounce: 2 cycles high then 10 low.
        add(2, 1, 0, 0, 0, 0, 0);
        add(2, 0, 0, 0, 0, 1, 0);
        add(8, 0, 0, 0, 0, 0, 1);
        // 1,0,1,0 at 1-cycle spacing.
        add(1, 1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 1, 2);
        add(3, 0, 0, 0, 0, 0, 3);
        // Plain clear, two glitches to reach 2, then clear coincident with a glitch.
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 1, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 1, 2);
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        // One more glitch so reset has a nonzero count to clear.
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1);
        // Reset mid-qualification (S_CHK_HI, cnt=2), then requalify.
        add(2, 1, 0, 0, 0, 0, 1);
        add(2, 1, 0, 0, 0, 1, 1);
        add(1, 1, 0, 1, 0, 0, 0);
        add(2, 1, 0, 0, 0, 0, 0);
        add(3, 1, 0, 0, 0, 1, 0);
        add(3, 1, 0, 0, 1, 0, 0);
        // One-cycle low glitch while high.
        add(1, 0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 1, 1, 0);
        add(4, 1, 0, 0, 1, 0, 1);
        // Clean fall to finish.
        add(2, 0, 0, 0, 1, 0, 1);
        add(3, 0, 0, 0, 1, 1, 1);
        add(4, 0, 0, 0, 0, 0, 1);

        prev_exp = 1'b0;
        prev_act = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            din        = vecs[i].din;
            clr_glitch = vecs[i].clr;
            rst        = vecs[i].rst;
            e.idx  = i;
            e.dout = vecs[i].dout;
            e.busy = vecs[i].busy;
            e.gc   = vecs[i].gc;
            exp_q.push_back(e);
            if (e.dout && !prev_exp) exp_rises++;
            prev_exp = e.dout;
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check("dout", e.idx, int'(dout), int'(e.dout));
            check("busy", e.idx, int'(busy), int'(e.busy));
            check("glitch_cnt", e.idx, int'(glitch_cnt), int'(e.gc));
            if (dout === 1'b1 && prev_act === 1'b0) act_rises++;
            prev_act = dout;
        end
        check("pe_pulses", 0, act_rises, exp_rises);

        // Saturation on the 2-bit counter: five isolated 2-cycle glitches.
        sat_exp = '{1, 2, 3, 3, 3};
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                din2 = (c < 2);
                @(posedge clk);
                #1;
                if (c == 2) check("sat_busy", g, int'(busy2), 1);
            end
            check("sat_glitch_cnt", g, int'(glitch_cnt2), sat_exp[g]);
            check("sat_dout", g, int'(dout2), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw, asynchronous, bouncing level input (button/switch/external strobe) into a clean, clock-synchronous level.
- Sits directly upstream of the positive-edge detector; its dout drives the detector's data input.
- Structure: N-flop synchronizer, then a 4-state stability FSM with a qualification counter, plus a saturating glitch counter for diagnostics.

Parameters:
- SYNC_STAGES, 2, flops in the synchronizer chain; legal range ≥2.
- STABLE_CYCLES, 4, consecutive synchronized samples required before dout changes; legal range ≥2.
- CNT_W, 8, width of glitch_cnt.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  1  raw asynchronous input level.
- clr_glitch  in  1  synchronous clear of glitch_cnt.
- dout  out  1  debounced, synchronized level (registered).
- busy  out  1  high while a candidate transition is being qualified.
- glitch_cnt  out  CNT_W  number of aborted qualifications; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Synchronizer flops ← 0; state ← S_LO; qual counter ← 0; dout ← 0; busy ← 0; glitch_cnt ← 0.
  - Reset overrides everything, including mid-qualification.
  - After release, a din already high must be fully requalified.
- Synchronizer: din_s = din delayed SYNC_STAGES edges. No other logic may sample din directly.
- FSM states: S_LO, S_CHK_HI, S_HI, S_CHK_LO. dout=1 only in S_HI and S_CHK_LO. busy=1 only in the CHK states.
- S_LO:
  - din_s=1 → S_CHK_HI, cnt ← 1.
  - Otherwise remain.
- S_CHK_HI:
  - din_s=1 and cnt == STABLE_CYCLES-1 → S_HI, dout ← 1, cnt ← 0.
  - din_s=1 and cnt < STABLE_CYCLES-1 → cnt ← cnt+1.
  - din_s=0 → S_LO, cnt ← 0, glitch event.
- S_HI / S_CHK_LO: mirror image of S_LO / S_CHK_HI with levels inverted.
- Latency:
  - For a clean din step, dout changes on rising edge number SYNC_STAGES+STABLE_CYCLES.
  - Edges are counted from the first edge that samples the new din value as 1.
  - With defaults, dout changes on the 6th edge.
- Rejection:
  - Any din_s pulse shorter than STABLE_CYCLES samples never reaches dout.
  - dout never toggles more than once per STABLE_CYCLES cycles.
- Glitch counter:
  - Increments by 1 on each glitch event; holds at 2^CNT_W-1.
  - clr_glitch=1 forces 0 and has priority over a coincident glitch event.
  - Reset has priority over both.
- qual counter width: $clog2(STABLE_CYCLES); no wrap, because it is cleared on every exit from a CHK state.
- All outputs are registered; no combinational path from din to any output.

Test Plan (defaults unless stated):
- Reset with din held: rst=1 for 2 edges while din=1 → dout=0, busy=0, glitch_cnt=0 throughout reset; after release, dout=1 on the 6th edge.
- Clean edges: din 0→1 held 10 cycles, then 1→0 held 10 cycles.
  - dout rises on the 6th edge after the step; busy=1 after edges 3,4,5 of the step only.
  - dout falls on the 6th edge after the fall.
  - Downstream edge detector emits exactly one pe pulse; glitch_cnt=0.
- Bounce rejection: din=1 for 2 cycles, then 0 for 10 → dout stays 0, glitch_cnt=1. Then din 1,0,1,0 at 1-cycle spacing → dout 0, glitch_cnt counts each aborted qualification.
- Saturation with CNT_W=2: 5 isolated 2-cycle glitches → glitch_cnt sequence 1,2,3,3,3.
- Clear priority: clr_glitch=1 on the same edge as a glitch event, with glitch_cnt=2 → glitch_cnt=0 after that edge.
- Reset mid-qualification: din high, rst pulsed 1 cycle while in S_CHK_HI with cnt=2 → dout=0, busy=0 after the reset edge; qualification restarts and dout rises SYNC_STAGES+STABLE_CYCLES edges after rst release.
